// File: rtl/scalar_rf_wb_ctrl_pkg.sv
// Shared definitions for the scalar register file write-back controller.
// Provides the register-file command encodings, requester index map and a
// small helper for the three-way round-robin pointer.

`ifndef SCALAR_RF_NOP
`define SCALAR_RF_NOP 2'b00
`endif
`ifndef SCALAR_RF_WRITE
`define SCALAR_RF_WRITE 2'b01
`endif

package scalar_rf_wb_ctrl_pkg;

  // Register-file command encodings driven on wb_rf_signal.
  localparam logic [1:0] RF_SIG_NOP   = `SCALAR_RF_NOP;
  localparam logic [1:0] RF_SIG_WRITE = `SCALAR_RF_WRITE;

  // Fixed requester index map.
  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LSU = 1;
  localparam int unsigned REQ_VEC = 2;

  localparam int unsigned NUM_REQ   = 3;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_REGS  = 32;

  typedef enum logic [1:0] {
    ReqAlu = 2'd0,
    ReqLsu = 2'd1,
    ReqVec = 2'd2
  } req_id_e;

  typedef logic [1:0] req_idx_t;

  // Successor of a requester index, wrapping 2 -> 0.
  function automatic req_idx_t rr_next(input req_idx_t idx);
    req_idx_t nxt;
    case (idx)
      2'd0:    nxt = 2'd1;
      2'd1:    nxt = 2'd2;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/scalar_rf_wb_ctrl_rr_arbiter3.sv
// Three-way round-robin arbiter for the register-file write port.
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   enable     - grant is produced and the pointer advances only when high
//   req_valid  - per-requester request
//   grant      - one-hot grant (also the accept strobe to the requester)
// The search starts at rr_ptr; after an accepted grant the pointer moves to
// the requester following the winner.

module rr_arbiter3
  import scalar_rf_wb_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] req_valid,
  output logic [2:0] grant
);

  req_idx_t   rr_ptr_q, rr_ptr_d;
  req_idx_t   pick_idx;
  req_idx_t   cand;
  logic [2:0] pick;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    cand     = rr_ptr_q;
    for (int i = 0; i < 3; i++) begin
      if (pick == 3'b000 && req_valid[cand]) begin
        pick[cand] = 1'b1;
        pick_idx   = cand;
      end
      cand = rr_next(cand);
    end
  end

  assign grant = enable ? pick : 3'b000;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (enable && pick != 3'b000) begin
      rr_ptr_d = rr_next(pick_idx);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/scalar_rf_wb_ctrl.sv
// Write-back controller for the 32-entry scalar register file.
// Shares the single write port among ALU, LSU and vector-extract results and
// keeps a per-register busy scoreboard for decode hazard checks.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   rdy_in              - global enable; low freezes all state and outputs
//   req_valid/rd/data   - packed per-requester write requests
//   req_ready           - one-hot accept to requesters
//   issue_valid/rd      - decode issue of an rd-writing instruction
//   issue_ready         - issue accepted (no WAW hazard on rd)
//   query_rs1/2         - decode source indices
//   rs1_busy/rs2_busy   - source has a pending write
//   wb_enabled, wb_rf_signal, wb_rd, wb_data - register-file write side

module scalar_rf_wb_ctrl
  import scalar_rf_wb_ctrl_pkg::*;
#(
  parameter int unsigned SCALAR_REG_LEN = 64,
  parameter int unsigned REQ_NUM        = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy_in,
  input  logic [REQ_NUM-1:0]            req_valid,
  input  logic [5*REQ_NUM-1:0]          req_rd,
  input  logic [SCALAR_REG_LEN*REQ_NUM-1:0] req_data,
  output logic [REQ_NUM-1:0]            req_ready,
  input  logic                          issue_valid,
  input  logic [4:0]                    issue_rd,
  output logic                          issue_ready,
  input  logic [4:0]                    query_rs1,
  input  logic [4:0]                    query_rs2,
  output logic                          rs1_busy,
  output logic                          rs2_busy,
  output logic                          wb_enabled,
  output logic [1:0]                    wb_rf_signal,
  output logic [4:0]                    wb_rd,
  output logic [SCALAR_REG_LEN-1:0]     wb_data
);

  // Combinational handshakes must read 0 while reset is held, whatever rdy_in does.
  logic active;
  assign active = rdy_in & rst;

  logic [REQ_NUM-1:0] grant;

  rr_arbiter3 u_arb (
    .clk       (clk),
    .rst       (rst),
    .enable    (active),
    .req_valid (req_valid),
    .grant     (grant)
  );

  assign req_ready = grant;

  // Select the granted requester's payload.
  logic [4:0]                sel_rd;
  logic [SCALAR_REG_LEN-1:0] sel_data;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < int'(REQ_NUM); i++) begin
      if (grant[i]) begin
        sel_rd   = req_rd[i*5 +: 5];
        sel_data = req_data[i*SCALAR_REG_LEN +: SCALAR_REG_LEN];
      end
    end
  end

  // Writes to x0 consume the grant but never reach the register file.
  logic wr_fire;
  assign wr_fire = (grant != '0) && (sel_rd != 5'd0);

  logic                      wb_enabled_q;
  logic [4:0]                wb_rd_q;
  logic [SCALAR_REG_LEN-1:0] wb_data_q;
  logic [NUM_REGS-1:0]       busy_q, busy_d;

  assign issue_ready = active && !busy_q[issue_rd];

  logic issue_fire;
  assign issue_fire = issue_valid && issue_ready && (issue_rd != 5'd0);

  // Clear lands on the edge that commits the write; a same-index set is
  // impossible because issue is blocked while that index is busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_enabled_q) begin
      busy_d[wb_rd_q] = 1'b0;
    end
    if (issue_fire) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_enabled_q <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      busy_q       <= '0;
    end else if (rdy_in) begin
      wb_enabled_q <= wr_fire;
      busy_q       <= busy_d;
      if (wr_fire) begin
        wb_rd_q   <= sel_rd;
        wb_data_q <= sel_data;
      end
    end
  end

  assign wb_enabled   = wb_enabled_q;
  assign wb_rf_signal = wb_enabled_q ? RF_SIG_WRITE : RF_SIG_NOP;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign rs1_busy     = busy_q[query_rs1];
  assign rs2_busy     = busy_q[query_rs2];

endmodule

// File: tb/tb_scalar_rf_wb_ctrl.sv
// Directed self-checking bench for scalar_rf_wb_ctrl.

module tb_scalar_rf_wb_ctrl;
  import scalar_rf_wb_ctrl_pkg::*;

  localparam int unsigned W = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy_in;
  logic [2:0]    req_valid;
  logic [14:0]   req_rd;
  logic [3*W-1:0] req_data;
  logic [2:0]    req_ready;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic          issue_ready;
  logic [4:0]    query_rs1, query_rs2;
  logic          rs1_busy, rs2_busy;
  logic          wb_enabled;
  logic [1:0]    wb_rf_signal;
  logic [4:0]    wb_rd;
  logic [W-1:0]  wb_data;

  int checks = 0;
  int errors = 0;

  scalar_rf_wb_ctrl #(.SCALAR_REG_LEN(W), .REQ_NUM(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy_in       (rdy_in),
    .req_valid    (req_valid),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .query_rs1    (query_rs1),
    .query_rs2    (query_rs2),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .wb_enabled   (wb_enabled),
    .wb_rf_signal (wb_rf_signal),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] rd,
                         input logic [63:0] d);
    req_valid[i]        = v;
    req_rd[i*5 +: 5]    = rd;
    req_data[i*W +: W]  = d;
  endtask

  initial begin
    // Reset held with busy-looking inputs.
    rst         = 1'b0;
    rdy_in      = 1'b1;
    req_valid   = 3'b111;
    req_rd      = 15'($urandom);
    req_data    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    issue_valid = 1'b1;
    issue_rd    = 5'($urandom_range(1, 31));
    query_rs1   = 5'($urandom);
    query_rs2   = 5'($urandom);
    repeat (3) tick();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_issue_ready", 64'(issue_ready), 64'd0);
    chk("rst_wb_en", 64'(wb_enabled), 64'd0);
    chk("rst_wb_sig", 64'(wb_rf_signal), 64'(RF_SIG_NOP));
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_rs1_busy", 64'(rs1_busy), 64'd0);
    chk("rst_rs2_busy", 64'(rs2_busy), 64'd0);

    req_valid   = 3'b000;
    req_rd      = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    query_rs1   = '0;
    query_rs2   = '0;
    rst         = 1'b1;
    tick();

    // Single write to x5.
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    #1;
    chk("w1_issue_ready", 64'(issue_ready), 64'd1);
    tick();
    issue_valid = 1'b0;
    query_rs1   = 5'd5;
    set_req(0, 1'b1, 5'd5, 64'h1234);
    #1;
    chk("w1_busy_set", 64'(rs1_busy), 64'd1);
    chk("w1_grant", 64'(req_ready), 64'b001);
    tick();
    set_req(0, 1'b0, 5'd0, 64'h0);
    #1;
    chk("w1_wb_en", 64'(wb_enabled), 64'd1);
    chk("w1_wb_sig", 64'(wb_rf_signal), 64'(RF_SIG_WRITE));
    chk("w1_wb_rd", 64'(wb_rd), 64'd5);
    chk("w1_wb_data", wb_data, 64'h1234);
    chk("w1_busy_n1", 64'(rs1_busy), 64'd1);
    tick();
    chk("w1_wb_en_off", 64'(wb_enabled), 64'd0);
    chk("w1_wb_sig_nop", 64'(wb_rf_signal), 64'(RF_SIG_NOP));
    chk("w1_busy_clr", 64'(rs1_busy), 64'd0);

    // Asynchronous reset pulse brings rr_ptr back to ALU.
    rst = 1'b0;
    #1;
    rst = 1'b1;

    // Round-robin with all three requesters valid.
    set_req(0, 1'b1, 5'd1, 64'hA1);
    set_req(1, 1'b1, 5'd2, 64'hB2);
    set_req(2, 1'b1, 5'd3, 64'hC3);
    #1;
    chk("rr_g0", 64'(req_ready), 64'b001);
    tick();
    chk("rr_g1", 64'(req_ready), 64'b010);
    chk("rr_wb0_en", 64'(wb_enabled), 64'd1);
    chk("rr_wb0_rd", 64'(wb_rd), 64'd1);
    chk("rr_wb0_data", wb_data, 64'hA1);
    tick();
    chk("rr_g2", 64'(req_ready), 64'b100);
    chk("rr_wb1_en", 64'(wb_enabled), 64'd1);
    chk("rr_wb1_rd", 64'(wb_rd), 64'd2);
    chk("rr_wb1_data", wb_data, 64'hB2);
    tick();
    chk("rr_g3", 64'(req_ready), 64'b001);
    chk("rr_wb2_en", 64'(wb_enabled), 64'd1);
    chk("rr_wb2_rd", 64'(wb_rd), 64'd3);
    chk("rr_wb2_data", wb_data, 64'hC3);
    tick();
    req_valid = 3'b000;
    chk("rr_wb3_en", 64'(wb_enabled), 64'd1);
    chk("rr_wb3_rd", 64'(wb_rd), 64'd1);

    // rr_ptr is now at LSU; reset while its write is pending drops it.
    set_req(1, 1'b1, 5'd4, 64'hD4);
    #1;
    chk("rd_grant", 64'(req_ready), 64'b010);
    tick();
    set_req(1, 1'b0, 5'd0, 64'h0);
    chk("rd_wb_en", 64'(wb_enabled), 64'd1);
    chk("rd_wb_rd", 64'(wb_rd), 64'd4);
    rst = 1'b0;
    #1;
    chk("rd_wb_en_rst", 64'(wb_enabled), 64'd0);
    chk("rd_wb_rd_rst", 64'(wb_rd), 64'd0);
    chk("rd_wb_data_rst", wb_data, 64'd0);
    rst = 1'b1;
    tick();
    chk("rd_no_retry", 64'(wb_enabled), 64'd0);

    // WAW stall on x7.
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    #1;
    chk("waw_first_issue", 64'(issue_ready), 64'd1);
    tick();
    query_rs2 = 5'd7;
    #1;
    chk("waw_stall", 64'(issue_ready), 64'd0);
    chk("waw_busy", 64'(rs2_busy), 64'd1);
    issue_rd = 5'd0;
    #1;
    chk("waw_x0_issue", 64'(issue_ready), 64'd1);
    tick();
    issue_rd = 5'd7;
    set_req(2, 1'b1, 5'd7, 64'h77);
    #1;
    chk("waw_stall_n", 64'(issue_ready), 64'd0);
    chk("waw_vec_grant", 64'(req_ready), 64'b100);
    tick();
    set_req(2, 1'b0, 5'd0, 64'h0);
    #1;
    chk("waw_wb_en", 64'(wb_enabled), 64'd1);
    chk("waw_wb_rd", 64'(wb_rd), 64'd7);
    chk("waw_stall_n1", 64'(issue_ready), 64'd0);
    tick();
    chk("waw_release", 64'(issue_ready), 64'd1);
    chk("waw_busy_clr", 64'(rs2_busy), 64'd0);
    issue_valid = 1'b0;

    // Mark x9 busy for the freeze check.
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    tick();
    issue_valid = 1'b0;
    query_rs1   = 5'd9;
    query_rs2   = 5'd13;
    #1;
    chk("x9_busy", 64'(rs1_busy), 64'd1);

    // x0 write from LSU: accepted, no write, pointer moves to VEC.
    set_req(1, 1'b1, 5'd0, 64'hEE);
    #1;
    chk("x0_grant", 64'(req_ready), 64'b010);
    tick();
    set_req(1, 1'b0, 5'd0, 64'h0);
    #1;
    chk("x0_wb_en", 64'(wb_enabled), 64'd0);
    chk("x0_wb_sig", 64'(wb_rf_signal), 64'(RF_SIG_NOP));
    set_req(0, 1'b1, 5'd11, 64'hB0B);
    set_req(1, 1'b1, 5'd0, 64'hEE);
    set_req(2, 1'b1, 5'd12, 64'hC0C);
    #1;
    chk("x0_ptr_vec", 64'(req_ready), 64'b100);
    tick();
    chk("fz_pre_wb_rd", 64'(wb_rd), 64'd12);

    // Freeze mid-stream.
    rdy_in      = 1'b0;
    issue_valid = 1'b1;
    issue_rd    = 5'd13;
    #1;
    chk("fz_req_ready", 64'(req_ready), 64'd0);
    chk("fz_issue_ready", 64'(issue_ready), 64'd0);
    chk("fz_wb_en", 64'(wb_enabled), 64'd1);
    tick();
    chk("fz_wb_en_hold", 64'(wb_enabled), 64'd1);
    chk("fz_wb_sig_hold", 64'(wb_rf_signal), 64'(RF_SIG_WRITE));
    chk("fz_wb_rd_hold", 64'(wb_rd), 64'd12);
    chk("fz_wb_data_hold", wb_data, 64'hC0C);
    chk("fz_busy9_hold", 64'(rs1_busy), 64'd1);
    chk("fz_busy13_none", 64'(rs2_busy), 64'd0);
    tick();
    chk("fz_wb_rd_hold2", 64'(wb_rd), 64'd12);
    issue_valid = 1'b0;
    rdy_in      = 1'b1;
    #1;
    chk("fz_resume_grant", 64'(req_ready), 64'b001);
    tick();
    chk("fz_resume_wb_rd", 64'(wb_rd), 64'd11);
    chk("fz_resume_wb_data", wb_data, 64'hB0B);
    chk("fz_next_grant", 64'(req_ready), 64'b010);
    req_valid = 3'b000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scalar_rf_wb_ctrl.md
# scalar_rf_wb_ctrl

Write-back controller for the 32-entry scalar register file. It shares the file's single write port among three result producers: scalar ALU, load unit, and vector unit for scalar extracts. It also keeps a per-register busy scoreboard that the decode stage queries before reading rs1/rs2. It sits between the execute/memory stages and the scalar register file, and drives that file's write-side inputs.

## Interface
Parameters:
- SCALAR_REG_LEN, 64, scalar register / write data width
- REQ_NUM, 3, number of write requesters (fixed index map: 0 ALU, 1 LSU, 2 VEC)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- rdy_in  in  1  global enable; when low, all state and outputs are frozen
- req_valid  in  REQ_NUM  per-requester write request
- req_rd  in  5*REQ_NUM  per-requester destination index (packed, requester i at [5i+4:5i])
- req_data  in  SCALAR_REG_LEN*REQ_NUM  per-requester write data (packed)
- req_ready  out  REQ_NUM  one-hot grant/accept, combinational
- issue_valid  in  1  decode issues an instruction that writes rd
- issue_rd  in  5  destination of the issued instruction
- issue_ready  out  1  issue accepted (combinational)
- query_rs1, query_rs2  in  5 each  source indices from decode
- rs1_busy, rs2_busy  out  1 each  source has a pending write (combinational)
- wb_enabled  out  1  to register file write_back_enabled
- wb_rf_signal  out  2  to register file rf_signal (`SCALAR_RF_WRITE` when enabled, else `SCALAR_RF_NOP`)
- wb_rd  out  5  to register file rd
- wb_data  out  SCALAR_REG_LEN  to register file data

## Operation
- Arbitration is round-robin over the valid requesters, searching from rr_ptr. The grant is asserted on req_ready only when rdy_in=1. On acceptance, rr_ptr becomes (granted+1) mod 3. rr_ptr resets to 0.
- A requester holds valid, rd and data stable until it sees ready. At most one acceptance occurs per cycle.
- An accepted request registers wb_rd/wb_data and sets wb_enabled=1 with wb_rf_signal=`SCALAR_RF_WRITE` for exactly one cycle. With no acceptance, wb_enabled=0 and wb_rf_signal=`SCALAR_RF_NOP`.
- A request with rd=0 is accepted (its ready pulses and it consumes the grant), but no write is produced: wb_enabled stays 0.
- Scoreboard: busy[31:0].
  - issue_ready = rdy_in && (issue_rd==0 || !busy[issue_rd]). The WAW stall is handled by holding issue_ready low.
  - Accepted issue with issue_rd!=0 sets busy[issue_rd].
  - busy[wb_rd] clears at the edge that ends the wb_enabled cycle, i.e. the same edge at which the register file commits the data.
  - busy[0] is constant 0.
- rsX_busy = busy[query_rsX]. Decode must not read a busy source.
- Simultaneous set and clear of the same index cannot occur, because issue is blocked while busy. Sets and clears on different indices in the same cycle both take effect.
- With rdy_in=0: no grant, no issue, busy and rr_ptr unchanged, wb_* registers hold.

## Timing
- Reset (asynchronous, rst=0): busy=0, rr_ptr=0, wb_enabled=0, wb_rf_signal=`SCALAR_RF_NOP`, wb_rd=0, wb_data=0, req_ready=0, issue_ready=0.
- Request accepted in cycle N: wb_* valid during cycle N+1, the register file writes at the end of N+1, and busy reads 0 from cycle N+2.
- Sustained throughput is one write per cycle.
- Reset asserted mid-operation discards any pending write; it is not retried.

## Structure
- Shared defines: `SCALAR_RF_WRITE`, `SCALAR_RF_NOP`, requester index constants (REQ_ALU, REQ_LSU, REQ_VEC).
- Sub-module rr_arbiter3: the round-robin grant plus rr_ptr register.
- Scoreboard and wb output registers live in the top module.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs at reset values, busy=0.
- Single write: issue rd=5 → rs1_busy(5)=1. ALU request rd=5, data=0x1234 in cycle N → wb_enabled=1, wb_rd=5, wb_data=0x1234 in N+1, rs1_busy(5)=0 in N+2.
- Round-robin fairness: all three requesters valid continuously → grant order ALU, LSU, VEC, ALU; one wb_enabled per cycle.
- WAW stall: rd=7 busy, issue rd=7 → issue_ready=0 until the cycle after rd=7 is written back; issue rd=0 is always accepted and never sets busy.
- x0 write: LSU request rd=0 → req_ready[1]=1, wb_enabled stays 0, rr_ptr advances to 2.
- Freeze: pull rdy_in low mid-stream → req_ready=0, issue_ready=0, wb_* and busy unchanged; raise it again → arbitration resumes from the saved rr_ptr.
